clk_div_prog: RTL and testbench

Multi-channel programmable clock-enable/clock divider generating `N_CH` independent divided outputs from one fast system clock. Each channel has a runtime-writable period and high-time, so duty cycle is programmable. New settings are shadow-buffered and take effect only at a period boundary, so output waveforms never glitch. The block sits between the board clock input and slow peripherals or a slowed core clock. It replaces the fixed 50% ÷10000 divider.

---
 rtl/clk_div_pkg.sv | 13 +
 rtl/clk_div_ch.sv | 61 ++++++
 rtl/clk_div_prog.sv | 42 ++++
 tb/tb_clk_div_prog.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: reset defaults, channel FSM states and channel-select width helper
package clk_div_pkg;

    localparam int DEF_DIV = 9999;
    localparam int DEF_HIGH = 5000;

    typedef enum logic {IDLE, RUN} state_t;

    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divider channel with shadowed period/high-time and glitch-free reload
module clk_div_ch #(
    parameter int CNT_W = 16,
    parameter int DEF_DIV = clk_div_pkg::DEF_DIV,
    parameter int DEF_HIGH = clk_div_pkg::DEF_HIGH
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic [CNT_W-1:0] wr_high,
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);
    import clk_div_pkg::*;

    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, div, div_n, high, high_n, s_div, s_high;
    logic at_end, ld, pend_n;

    // Active registers reload only in IDLE or at a running boundary; a write on
    // that same edge bypasses the shadow so it is never lost or delayed.
    always_comb begin
        at_end = cnt == div;
        ld = state == IDLE || (en && at_end);
        state_n = en ? RUN : IDLE;
        div_n = !ld ? div : wr ? wr_div : pend ? s_div : div;
        high_n = !ld ? high : wr ? wr_high : pend ? s_high : high;
        pend_n = !ld && (wr || pend);
        cnt_n = (!en || state == IDLE || at_end) ? '0 : cnt + 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            div <= CNT_W'(DEF_DIV);
            high <= CNT_W'(DEF_HIGH);
            s_div <= CNT_W'(DEF_DIV);
            s_high <= CNT_W'(DEF_HIGH);
            pend <= 1'b0;
            clk_out <= 1'b0;
            tick <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            div <= div_n;
            high <= high_n;
            pend <= pend_n;
            if (wr) begin
                s_div <= wr_div;
                s_high <= wr_high;
            end
            clk_out <= en && (cnt_n < high_n);
            tick <= en && (state == IDLE || at_end);
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: N_CH independent programmable clock dividers sharing one write port
module clk_div_prog #(
    parameter int N_CH = 4,
    parameter int CNT_W = 16,
    parameter int DEF_DIV = clk_div_pkg::DEF_DIV,
    parameter int DEF_HIGH = clk_div_pkg::DEF_HIGH
) (
    input  logic                                  clk_in,
    input  logic                                  rst,
    input  logic [N_CH-1:0]                       en,
    input  logic                                  wr_en,
    input  logic [clk_div_pkg::ch_w(N_CH)-1:0]    wr_ch,
    input  logic [CNT_W-1:0]                      wr_div,
    input  logic [CNT_W-1:0]                      wr_high,
    output logic [N_CH-1:0]                       clk_out,
    output logic [N_CH-1:0]                       tick,
    output logic [N_CH-1:0]                       pend
);
    import clk_div_pkg::*;

    localparam int CH_W = ch_w(N_CH);

    // Out-of-range channel numbers match no instance, so such writes drop out.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clk_div_ch #(
            .CNT_W(CNT_W),
            .DEF_DIV(DEF_DIV),
            .DEF_HIGH(DEF_HIGH)
        ) u_ch (
            .clk_in(clk_in),
            .rst(rst),
            .en(en[i]),
            .wr(wr_en && wr_ch == CH_W'(i)),
            .wr_div(wr_div),
            .wr_high(wr_high),
            .clk_out(clk_out[i]),
            .tick(tick[i]),
            .pend(pend[i])
        );
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed checks of reset defaults, reload, duty extremes, enable and reset
module tb_clk_div_prog;

    localparam int N_CH = 3;
    localparam int CNT_W = 16;

    logic clk_in = 1'b0;
    logic rst = 1'b0;
    logic [N_CH-1:0] en = '0;
    logic wr_en = 1'b0;
    logic [1:0] wr_ch = '0;
    logic [CNT_W-1:0] wr_div = '0;
    logic [CNT_W-1:0] wr_high = '0;
    logic [N_CH-1:0] clk_out, tick, pend;

    int checks = 0;
    int errors = 0;
    int hi, tk;
    logic [14:0] clk_v, tick_v, pend_v;

    clk_div_prog #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .clk_in(clk_in),
        .rst(rst),
        .en(en),
        .wr_en(wr_en),
        .wr_ch(wr_ch),
        .wr_div(wr_div),
        .wr_high(wr_high),
        .clk_out(clk_out),
        .tick(tick),
        .pend(pend)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic prog(input int ch, input int d, input int h);
        wr_en = 1'b1;
        wr_ch = 2'(ch);
        wr_div = CNT_W'(d);
        wr_high = CNT_W'(h);
        step();
        wr_en = 1'b0;
        step();
    endtask

    task automatic run(input int ch, input int n, output int n_hi, output int n_tk);
        n_hi = 0;
        n_tk = 0;
        for (int c = 0; c < n; c++) begin
            n_hi += int'(clk_out[ch]);
            n_tk += int'(tick[ch]);
            step();
        end
    endtask

    initial begin
        step();
        step();
        check("reset clk_out", 32'(clk_out), 0);
        check("reset tick", 32'(tick), 0);
        check("reset pend", 32'(pend), 0);

        rst = 1'b1;
        en[0] = 1'b1;
        step();
        check("first tick", 32'(tick[0]), 1);
        check("first clk_out", 32'(clk_out[0]), 1);
        run(0, 10000, hi, tk);
        check("default high count", 32'(hi), 5000);
        check("default tick count", 32'(tk), 1);
        check("default next tick", 32'(tick[0]), 1);

        en[0] = 1'b0;
        step();
        wr_en = 1'b1;
        wr_ch = 2'd0;
        wr_div = 16'd9;
        wr_high = 16'd5;
        step();
        check("idle write no pend", 32'(pend[0]), 0);
        wr_en = 1'b0;
        step();
        en[0] = 1'b1;
        step();
        for (int c = 0; c < 15; c++) begin
            clk_v[c] = clk_out[0];
            tick_v[c] = tick[0];
            pend_v[c] = pend[0];
            wr_en = (c == 4);
            wr_div = 16'd3;
            wr_high = 16'd1;
            step();
        end
        wr_en = 1'b0;
        check("glitch clk pattern", 32'(clk_v), 32'h441F);
        check("glitch tick pattern", 32'(tick_v), 32'h4401);
        check("glitch pend pattern", 32'(pend_v), 32'h03E0);

        prog(1, 4, 0);
        en[1] = 1'b1;
        step();
        run(1, 10, hi, tk);
        check("high0 high count", 32'(hi), 0);
        check("high0 tick count", 32'(tk), 2);
        en[1] = 1'b0;
        step();
        prog(1, 9, 20);
        en[1] = 1'b1;
        step();
        run(1, 10, hi, tk);
        check("high>div high count", 32'(hi), 10);
        check("high>div tick count", 32'(tk), 1);
        en[1] = 1'b0;
        step();
        prog(1, 0, 1);
        en[1] = 1'b1;
        step();
        run(1, 10, hi, tk);
        check("div0 tick count", 32'(tk), 10);
        check("div0 high count", 32'(hi), 10);

        en[0] = 1'b0;
        step();
        prog(0, 9, 8);
        en[0] = 1'b1;
        step();
        for (int c = 0; c < 6; c++) step();
        check("cnt6 clk_out", 32'(clk_out[0]), 1);
        en[0] = 1'b0;
        step();
        check("disable clk_out", 32'(clk_out[0]), 0);
        check("disable tick", 32'(tick[0]), 0);
        en[0] = 1'b1;
        step();
        check("reenable tick", 32'(tick[0]), 1);
        check("reenable clk_out", 32'(clk_out[0]), 1);
        step();
        check("reenable tick drop", 32'(tick[0]), 0);

        prog(2, 3, 2);
        en[2] = 1'b1;
        step();
        for (int c = 0; c < 3; c++) step();
        wr_en = 1'b1;
        wr_ch = 2'd2;
        wr_div = 16'd5;
        wr_high = 16'd4;
        step();
        wr_en = 1'b0;
        check("collision tick", 32'(tick[2]), 1);
        check("collision pend", 32'(pend[2]), 0);
        check("collision clk_out", 32'(clk_out[2]), 1);
        run(2, 6, hi, tk);
        check("collision high count", 32'(hi), 4);
        check("collision tick count", 32'(tk), 1);
        wr_en = 1'b1;
        wr_ch = 2'd3;
        wr_div = 16'd1;
        wr_high = 16'd0;
        step();
        wr_en = 1'b0;
        check("out of range pend", 32'(pend), 0);
        run(2, 6, hi, tk);
        check("out of range high count", 32'(hi), 4);
        check("out of range tick count", 32'(tk), 1);

        wr_en = 1'b1;
        wr_ch = 2'd0;
        wr_div = 16'd2;
        wr_high = 16'd1;
        step();
        wr_en = 1'b0;
        check("running write pend", 32'(pend[0]), 1);
        #2 rst = 1'b0;
        #1;
        check("async reset clk_out", 32'(clk_out), 0);
        check("async reset tick", 32'(tick), 0);
        check("async reset pend", 32'(pend), 0);
        step();
        rst = 1'b1;
        en = 3'b001;
        step();
        run(0, 10000, hi, tk);
        check("post reset high count", 32'(hi), 5000);
        check("post reset tick count", 32'(tk), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
